// File: rtl/sram_arb_pkg.sv
// Shared definitions for the two-requester SRAM port arbiter:
// default widths, FSM state encoding and the requester index type.
package sram_arb_pkg;

  localparam int AW_DEF = 10;
  localparam int DW_DEF = 8;

  typedef enum logic {
    IDLE  = 1'b0,
    ISSUE = 1'b1
  } arb_state_t;

  typedef logic req_idx_t;

  localparam req_idx_t REQ0 = 1'b0;
  localparam req_idx_t REQ1 = 1'b1;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin picker: takes the eligibility mask and the current
// pointer, returns a one-hot grant and the pointer for the next decision.
// The pointer always moves to the requester that did not win, and is left
// untouched when nobody is eligible.
module rr_arb2
  import sram_arb_pkg::*;
(
  input  logic [1:0] elig,
  input  req_idx_t   ptr,
  output logic [1:0] grant,
  output req_idx_t   next_ptr
);

  // Lone eligible requester wins outright; a tie is broken by the pointer
  always_comb begin
    grant    = 2'b00;
    next_ptr = ptr;
    case (elig)
      2'b01: begin
        grant    = 2'b01;
        next_ptr = REQ1;
      end
      2'b10: begin
        grant    = 2'b10;
        next_ptr = REQ0;
      end
      2'b11: begin
        if (ptr == REQ0) begin
          grant    = 2'b01;
          next_ptr = REQ1;
        end else begin
          grant    = 2'b10;
          next_ptr = REQ0;
        end
      end
      default: begin
        grant    = 2'b00;
        next_ptr = ptr;
      end
    endcase
  end

endmodule

// File: rtl/sram_port_arbiter.sv
// Shares one synchronous SRAM port (1-cycle read latency) between two
// requesters. A winner is picked every rising edge; the grant and the SRAM
// command appear together in the following cycle, and read data returns to
// the reader one cycle after that. A requester is ignored on the edge right
// after its grant so it has time to drop or replace its request.
// Optional build macro: SRAM_ARB_STATS_EN adds 16-bit saturating grant
// counters gcnt0 / gcnt1.
module sram_port_arbiter
  import sram_arb_pkg::*;
#(
  parameter int AW = AW_DEF,
  parameter int DW = DW_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req0,
  input  logic          req1,
  input  logic          we0,
  input  logic          we1,
  input  logic [AW-1:0] ad0,
  input  logic [AW-1:0] ad1,
  input  logic [DW-1:0] in0,
  input  logic [DW-1:0] in1,
  output logic          gnt0,
  output logic          gnt1,
  output logic          rvalid0,
  output logic          rvalid1,
  output logic [DW-1:0] rdata,
  output logic          sram_en,
  output logic          sram_we,
  output logic [AW-1:0] sram_ad,
  output logic [DW-1:0] sram_in,
  input  logic [DW-1:0] sram_out
`ifdef SRAM_ARB_STATS_EN
  ,
  output logic [15:0]   gcnt0,
  output logic [15:0]   gcnt1
`endif
);

  arb_state_t    state;
  req_idx_t      ptr;
  req_idx_t      next_ptr;
  logic [1:0]    gnt_q;
  logic [1:0]    grant;
  logic [1:0]    elig;
  logic          we_q;
  logic [AW-1:0] ad_q;
  logic [DW-1:0] in_q;
  logic [1:0]    rv_q;
  logic [DW-1:0] rdata_q;

  // A requester granted on the previous edge sits out this edge
  assign elig = {req1, req0} & ~gnt_q;

  rr_arb2 u_rr_arb2 (
    .elig     (elig),
    .ptr      (ptr),
    .grant    (grant),
    .next_ptr (next_ptr)
  );

  // Arbitration FSM: registers the grant pulse and the SRAM command of the winner
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      ptr   <= REQ0;
      gnt_q <= 2'b00;
      we_q  <= 1'b0;
      ad_q  <= '0;
      in_q  <= '0;
    end else begin
      state <= (|grant) ? ISSUE : IDLE;
      ptr   <= next_ptr;
      gnt_q <= grant;
      if (grant[0]) begin
        we_q <= we0;
        ad_q <= ad0;
        in_q <= in0;
      end else if (grant[1]) begin
        we_q <= we1;
        ad_q <= ad1;
        in_q <= in1;
      end else begin
        we_q <= 1'b0;
      end
    end
  end

  // Read return: flag the reader one cycle after its read hits the port and latch the data
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rv_q    <= 2'b00;
      rdata_q <= '0;
    end else begin
      rv_q <= (state == ISSUE && !we_q) ? gnt_q : 2'b00;
      if (|rv_q) begin
        rdata_q <= sram_out;
      end
    end
  end

  assign gnt0    = gnt_q[0];
  assign gnt1    = gnt_q[1];
  assign sram_en = (state == ISSUE);
  assign sram_we = we_q;
  assign sram_ad = ad_q;
  assign sram_in = in_q;
  assign rvalid0 = rv_q[0];
  assign rvalid1 = rv_q[1];
  // SRAM data only arrives in the rvalid cycle, so pass it straight through then
  assign rdata   = (|rv_q) ? sram_out : rdata_q;

`ifdef SRAM_ARB_STATS_EN
  // Saturating per-requester grant counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gcnt0 <= 16'd0;
      gcnt1 <= 16'd0;
    end else begin
      if (grant[0] && gcnt0 != 16'hFFFF) begin
        gcnt0 <= gcnt0 + 16'd1;
      end
      if (grant[1] && gcnt1 != 16'hFFFF) begin
        gcnt1 <= gcnt1 + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Self-checking bench for sram_port_arbiter: directed scenarios followed by
// random traffic, all compared against a transaction-level reference model.
module tb_sram_port_arbiter;

  localparam int AW = 10;
  localparam int DW = 8;

  logic          clk;
  logic          rst_n;
  logic          req0, req1, we0, we1;
  logic [AW-1:0] ad0, ad1;
  logic [DW-1:0] in0, in1;
  logic          gnt0, gnt1, rvalid0, rvalid1;
  logic [DW-1:0] rdata;
  logic          sram_en, sram_we;
  logic [AW-1:0] sram_ad;
  logic [DW-1:0] sram_in;
  logic [DW-1:0] sram_out;
`ifdef SRAM_ARB_STATS_EN
  logic [15:0]   gcnt0, gcnt1;
`endif

  int n_compared   = 0;
  int n_mismatched = 0;

  // SRAM behaviour and its reference copy
  logic [DW-1:0] sram_mem [0:(1<<AW)-1];
  logic [DW-1:0] mref     [0:(1<<AW)-1];

  // Reference model state
  logic [1:0]    m_gnt;
  logic          m_en;
  logic          m_we;
  logic [AW-1:0] m_ad;
  logic [DW-1:0] m_in;
  int            m_who;
  int            m_ptr;
  int            m_cnt [2];
  logic [1:0]    e_rv;
  logic [DW-1:0] e_rdata;

  sram_port_arbiter #(.AW(AW), .DW(DW)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req0     (req0),
    .req1     (req1),
    .we0      (we0),
    .we1      (we1),
    .ad0      (ad0),
    .ad1      (ad1),
    .in0      (in0),
    .in1      (in1),
    .gnt0     (gnt0),
    .gnt1     (gnt1),
    .rvalid0  (rvalid0),
    .rvalid1  (rvalid1),
    .rdata    (rdata),
    .sram_en  (sram_en),
    .sram_we  (sram_we),
    .sram_ad  (sram_ad),
    .sram_in  (sram_in),
    .sram_out (sram_out)
`ifdef SRAM_ARB_STATS_EN
    ,
    .gcnt0    (gcnt0),
    .gcnt1    (gcnt1)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous SRAM with one cycle of read latency
  always @(posedge clk) begin
    if (sram_en) begin
      if (sram_we) sram_mem[sram_ad] <= sram_in;
      else         sram_out <= sram_mem[sram_ad];
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_compared++;
    assert (obs === exp) else begin
      n_mismatched++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic modelReset();
    m_gnt    = 2'b00;
    m_en     = 1'b0;
    m_we     = 1'b0;
    m_ad     = '0;
    m_in     = '0;
    m_who    = 0;
    m_ptr    = 0;
    m_cnt[0] = 0;
    m_cnt[1] = 0;
    e_rv     = 2'b00;
    e_rdata  = '0;
  endtask

  // One rising edge of the reference: retire last cycle's access, then arbitrate
  task automatic modelEdge();
    int   who;
    logic el0, el1;
    e_rv = 2'b00;
    if (m_en) begin
      if (m_we) mref[m_ad] = m_in;
      else begin
        e_rv[m_who] = 1'b1;
        e_rdata     = mref[m_ad];
      end
    end
    el0 = req0 && !m_gnt[0];
    el1 = req1 && !m_gnt[1];
    who = -1;
    if (el0 && el1) who = m_ptr;
    else if (el0)   who = 0;
    else if (el1)   who = 1;
    m_gnt = 2'b00;
    m_en  = 1'b0;
    if (who >= 0) begin
      m_gnt[who] = 1'b1;
      m_en       = 1'b1;
      m_who      = who;
      m_ptr      = 1 - who;
      m_we       = (who == 1) ? we1 : we0;
      m_ad       = (who == 1) ? ad1 : ad0;
      m_in       = (who == 1) ? in1 : in0;
      if (m_cnt[who] < 65535) m_cnt[who]++;
    end
  endtask

  task automatic checkCycle();
    checkOutput("gnt0", {31'd0, gnt0}, {31'd0, m_gnt[0]});
    checkOutput("gnt1", {31'd0, gnt1}, {31'd0, m_gnt[1]});
    checkOutput("sram_en", {31'd0, sram_en}, {31'd0, m_en});
    checkOutput("rvalid0", {31'd0, rvalid0}, {31'd0, e_rv[0]});
    checkOutput("rvalid1", {31'd0, rvalid1}, {31'd0, e_rv[1]});
    checkOutput("rdata", {24'd0, rdata}, {24'd0, e_rdata});
    if (m_en) begin
      checkOutput("sram_we", {31'd0, sram_we}, {31'd0, m_we});
      checkOutput("sram_ad", {22'd0, sram_ad}, {22'd0, m_ad});
      checkOutput("sram_in", {24'd0, sram_in}, {24'd0, m_in});
    end
`ifdef SRAM_ARB_STATS_EN
    checkOutput("gcnt0", {16'd0, gcnt0}, m_cnt[0]);
    checkOutput("gcnt1", {16'd0, gcnt1}, m_cnt[1]);
`endif
  endtask

  task automatic tick();
    @(posedge clk);
    modelEdge();
    #1;
    checkCycle();
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_gnt"}, {30'd0, gnt1, gnt0}, 32'd0);
    checkOutput({tag, "_rvalid"}, {30'd0, rvalid1, rvalid0}, 32'd0);
    checkOutput({tag, "_en_we"}, {30'd0, sram_en, sram_we}, 32'd0);
    checkOutput({tag, "_ad"}, {22'd0, sram_ad}, 32'd0);
    checkOutput({tag, "_in"}, {24'd0, sram_in}, 32'd0);
    checkOutput({tag, "_rdata"}, {24'd0, rdata}, 32'd0);
  endtask

  task automatic applyReset();
    rst_n = 1'b0;
    req0  = 1'b0;
    req1  = 1'b0;
    modelReset();
    repeat (2) @(negedge clk);
    checkAllZero("reset");
    rst_n = 1'b1;
  endtask

  // Random requester: keeps a pending request stable, may replace it once granted
  task automatic applyStimulus(input int idx);
    logic          r, w;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    r = ($urandom_range(0, 3) != 0);
    w = $urandom_range(0, 1) == 1;
    a = AW'($urandom_range(0, 15));
    d = DW'($urandom);
    if (idx == 0) begin
      if (!req0 || m_gnt[0]) begin
        req0 = r; we0 = w; ad0 = a; in0 = d;
      end
    end else begin
      if (!req1 || m_gnt[1]) begin
        req1 = r; we1 = w; ad1 = a; in1 = d;
      end
    end
  endtask

  initial begin
    int g0;
    for (int i = 0; i < (1 << AW); i++) begin
      sram_mem[i] = '0;
      mref[i]     = '0;
    end
    rst_n = 1'b1;
    req0 = 1'b0; req1 = 1'b0; we0 = 1'b0; we1 = 1'b0;
    ad0 = '0; ad1 = '0; in0 = '0; in1 = '0;
    modelReset();
    #2;

    $display("[TB] write by requester 0 then read back by requester 1");
    applyReset();
    req0 = 1'b1; we0 = 1'b1; ad0 = 10'h01F; in0 = 8'hAA;
    tick();
    checkOutput("wr_gnt0", {31'd0, gnt0}, 32'd1);
    checkOutput("wr_we", {31'd0, sram_we}, 32'd1);
    checkOutput("wr_ad", {22'd0, sram_ad}, 32'h01F);
    checkOutput("wr_in", {24'd0, sram_in}, 32'hAA);
    req0 = 1'b0;
    req1 = 1'b1; we1 = 1'b0; ad1 = 10'h01F;
    tick();
    checkOutput("wr_no_rvalid", {30'd0, rvalid1, rvalid0}, 32'd0);
    checkOutput("rd_gnt1", {31'd0, gnt1}, 32'd1);
    req1 = 1'b0;
    tick();
    checkOutput("rd_rvalid1", {31'd0, rvalid1}, 32'd1);
    checkOutput("rd_rvalid0", {31'd0, rvalid0}, 32'd0);
    checkOutput("rd_rdata", {24'd0, rdata}, 32'hAA);
    tick();
    checkOutput("rd_hold", {24'd0, rdata}, 32'hAA);

    $display("[TB] both requesters held: alternating grants");
    applyReset();
    req0 = 1'b1; we0 = 1'b1; ad0 = 10'h010; in0 = 8'h11;
    req1 = 1'b1; we1 = 1'b1; ad1 = 10'h011; in1 = 8'h22;
    for (int k = 0; k < 6; k++) begin
      tick();
      checkOutput("rr_gnt0", {31'd0, gnt0}, (k % 2 == 0) ? 32'd1 : 32'd0);
      checkOutput("rr_gnt1", {31'd0, gnt1}, (k % 2 == 1) ? 32'd1 : 32'd0);
      checkOutput("rr_en", {31'd0, sram_en}, 32'd1);
    end
    req0 = 1'b0; req1 = 1'b0;
    tick();

    $display("[TB] single requester held: every other cycle");
    applyReset();
    req0 = 1'b1; we0 = 1'b0; ad0 = 10'h01F;
    g0 = 0;
    for (int k = 0; k < 6; k++) begin
      tick();
      checkOutput("solo_gnt0", {31'd0, gnt0}, (k % 2 == 0) ? 32'd1 : 32'd0);
      if (gnt0) g0++;
    end
    checkOutput("solo_count", g0, 32'd3);
    req0 = 1'b0;
    tick();

    $display("[TB] reset during an issued read");
    applyReset();
    req1 = 1'b1; we1 = 1'b0; ad1 = 10'h01F;
    tick();
    req1 = 1'b0;
    checkOutput("abort_issue", {30'd0, sram_en, gnt1}, 32'd3);
    rst_n = 1'b0;
    modelReset();
    #1;
    checkAllZero("abort");
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      checkOutput("abort_rvalid", {30'd0, rvalid1, rvalid0}, 32'd0);
    end

    $display("[TB] random traffic");
    applyReset();
    for (int k = 0; k < 3000; k++) begin
      applyStimulus(0);
      applyStimulus(1);
      tick();
      checkOutput("gnt_excl", {31'd0, gnt0 & gnt1}, 32'd0);
      checkOutput("rv_excl", {31'd0, rvalid0 & rvalid1}, 32'd0);
    end
    req0 = 1'b0; req1 = 1'b0;
    tick();

`ifdef SRAM_ARB_STATS_EN
    $display("[TB] grant counter saturation");
    applyReset();
    req1 = 1'b1; we1 = 1'b1; ad1 = 10'h002; in1 = 8'h55;
    repeat (140000) @(posedge clk);
    #1;
    checkOutput("gcnt1_sat", {16'd0, gcnt1}, 32'h0000FFFF);
    checkOutput("gcnt0_zero", {16'd0, gcnt0}, 32'd0);
    req1 = 1'b0;
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule

// File: doc/sram_port_arbiter.md
SRAM_PORT_ARBITER -- requirements
Module: sram_port_arbiter

Interface
REQ-001 Parameter AW, default 10, SRAM address width.
REQ-002 Parameter DW, default 8, SRAM data width.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous and active-low.
REQ-005 req0 / req1  input  1  access request from requester 0 / 1, held until granted.
REQ-006 we0 / we1  input  1  1 = write, 0 = read; held stable with req.
REQ-007 ad0 / ad1  input  AW  access address; held stable with req.
REQ-008 in0 / in1  input  DW  write data; held stable with req.
REQ-009 gnt0 / gnt1  output  1  one-cycle grant pulse; request accepted.
REQ-010 rvalid0 / rvalid1  output  1  one-cycle pulse; read data valid on rdata.
REQ-011 rdata  output  DW  read data returned to the requester flagged by rvalid.
REQ-012 sram_en, sram_we  output  1  SRAM port enable and write enable.
REQ-013 sram_ad  output  AW; sram_in  output  DW  SRAM port address and write data.
REQ-014 sram_out  input  DW  SRAM port read data, valid the cycle after a read enable.

Function
REQ-015 The block SHALL share one synchronous SRAM port (1-cycle read latency) between two requesters.
REQ-016 Arbitration SHALL be evaluated at each rising edge: on edge t, a winner is chosen from eligible requests and gnt, sram_en, sram_we, sram_ad and sram_in are registered, all visible in cycle t+1.
REQ-017 sram_en SHALL be high for exactly one cycle per grant; sram_we SHALL equal the winner's we; sram_ad/sram_in SHALL equal the winner's ad/in.
REQ-018 The FSM SHALL have states IDLE (sram_en=0) and ISSUE (sram_en=1). From either state, go to ISSUE if any eligible request exists, else IDLE.
REQ-019 A requester granted on edge t SHALL be ineligible on edge t+1 (req-drop window), then eligible again.
REQ-020 When both are eligible, the grant SHALL follow a round-robin pointer; after reset the pointer favours requester 0, and after each grant it points to the non-granted requester.
REQ-021 When one is eligible, it SHALL be granted regardless of the pointer; the pointer still updates per REQ-020.
REQ-022 For a read issued in cycle c (sram_en=1, sram_we=0), rvalid of that requester SHALL pulse in cycle c+1, with rdata = sram_out in that cycle.
REQ-023 Writes SHALL never assert rvalid; rdata SHALL hold its last value when no rvalid is asserted.
REQ-024 Sustained throughput SHALL be one access per cycle with both requesting, and one access every two cycles with a single requester.
REQ-025 gnt0 and gnt1 SHALL never be high together; rvalid0 and rvalid1 SHALL never be high together.

Reset
REQ-026 While rst_n=0: FSM=IDLE, pointer=requester 0, and gnt*, rvalid*, sram_en and sram_we SHALL be 0; sram_ad, sram_in and rdata SHALL be 0.
REQ-027 A reset asserted mid-access SHALL abort it: no pending rvalid is delivered after reset release.
REQ-028 The first grant SHALL occur no earlier than the first rising edge after rst_n deasserts.

Configuration
REQ-029 With macro SRAM_ARB_STATS_EN defined, the block SHALL add outputs gcnt0 / gcnt1 (16 bits).
REQ-030 Each gcnt SHALL count grants to its requester, saturate at 0xFFFF, and reset to 0.
REQ-031 Without SRAM_ARB_STATS_EN, these ports and counters SHALL be absent, with all other behaviour identical.

Structure
REQ-032 Package sram_arb_pkg SHALL hold the AW/DW defaults, the FSM state enum (IDLE, ISSUE) and the requester-index type.
REQ-033 The 2-way round-robin picker (eligibility mask plus pointer in, one-hot grant plus next pointer out) SHALL be sub-module rr_arb2.

Verification
REQ-034 Reset, then req0 write ad0=0x01F, in0=0xAA -> gnt0 and sram_en/sram_we with sram_ad=0x01F, sram_in=0xAA one cycle later; no rvalid.
REQ-035 req1 read ad1=0x01F after REQ-034 -> gnt1, then one cycle later rvalid1=1 and rdata=0xAA; rvalid0 stays 0.
REQ-036 req0 and req1 both held high for 6 grants after reset -> grant sequence 0,1,0,1,0,1 and sram_en continuously high.
REQ-037 req0 alone held for 6 cycles -> gnt0 in alternate cycles only (3 grants).
REQ-038 Assert rst_n=0 in the cycle a read is issued -> all outputs 0 immediately and no rvalid after release.
REQ-039 SRAM_ARB_STATS_EN defined, 70000 grants to requester 1 -> gcnt1=0xFFFF and gcnt0=0.
